// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass, a per-register
// busy scoreboard for in-flight producers, and a registered same-address write-conflict flag.
module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 1,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    input  logic                  rsv_valid,
    input  logic [AW-1:0]         rsv_addr,
    output logic [NREGS-1:0]      busy_vec,
    output logic                  wr_conflict
);

    logic [AW-1:0]    wa     [NWR];
    logic [XLEN-1:0]  wd     [NWR];
    logic [NWR-1:0]   wr_eff;
    logic [XLEN-1:0]  reg_val [NREGS];
    logic [NREGS-1:0] busy_all;
    logic             wr_conflict_q;
    logic             wr_conflict_d;

    // A write is effective only out of reset and never to the hardwired zero register,
    // so every consumer below (commit, bypass, scoreboard, conflict) sees the same qualification.
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wport
        assign wa[gi]     = waddr[gi*AW +: AW];
        assign wd[gi]     = wdata[gi*XLEN +: XLEN];
        assign wr_eff[gi] = rst_n && we[gi] && !((ZERO_REG != 0) && (wa[gi] == '0));
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [XLEN-1:0] val_q;
        logic [XLEN-1:0] val_d;
        logic            busy_q;
        logic            busy_d;
        logic            wr_hit;
        logic            rsv_hit;

        // Later ports overwrite earlier ones, so the highest-index writer wins.
        always_comb begin
            val_d  = val_q;
            wr_hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j] && (wa[j] == AW'(gi))) begin
                    val_d  = wd[j];
                    wr_hit = 1'b1;
                end
            end
        end

        assign rsv_hit = rsv_valid && (rsv_addr == AW'(gi)) && !((ZERO_REG != 0) && (gi == 0));

        // A reservation beats a same-cycle write: the new producer is still outstanding.
        always_comb begin
            busy_d = busy_q;
            if (rsv_hit) begin
                busy_d = 1'b1;
            end else if (wr_hit) begin
                busy_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                val_q  <= val_d;
                busy_q <= busy_d;
            end
        end

        assign reg_val[gi]  = val_q;
        assign busy_all[gi] = busy_q;
    end

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (wr_eff[j] && wr_eff[k] && (wa[j] == wa[k])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= wr_conflict_d;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[gi*AW +: AW];

        always_comb begin
            rd = reg_val[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_eff[j] && (wa[j] == ra)) begin
                        rd = wd[j];
                    end
                end
            end
            if (!rst_n || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
            end
        end

        assign rdata[gi*XLEN +: XLEN] = rd;
        // Busy is deliberately not bypassed: a same-cycle write does not clear it here.
        assign rbusy[gi] = rst_n && busy_all[ra] && !((ZERO_REG != 0) && (ra == '0));
    end

    assign busy_vec    = busy_all;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (dual-write bypass, no-bypass, wide/no-zero-reg)
// checked against expected values queued at stimulus time and popped when outputs are sampled.
module tb_regfile_mp;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    logic clk;
    logic rst_n;

    // Instance a: XLEN=32, NREGS=32, NRD=2, NWR=2, BYPASS=1, ZERO_REG=1
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;
    logic [1:0]  a_we;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;
    logic        a_rsv_valid;
    logic [4:0]  a_rsv_addr;
    logic [31:0] a_busy_vec;
    logic        a_wr_conflict;

    // Instance b: BYPASS=0, NWR=1
    logic [9:0]  b_raddr;
    logic [63:0] b_rdata;
    logic [1:0]  b_rbusy;
    logic [0:0]  b_we;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_rsv_valid;
    logic [4:0]  b_rsv_addr;
    logic [31:0] b_busy_vec;
    logic        b_wr_conflict;

    // Instance c: XLEN=64, NREGS=16, NRD=3, NWR=1, ZERO_REG=0
    logic [11:0]  c_raddr;
    logic [191:0] c_rdata;
    logic [2:0]   c_rbusy;
    logic [0:0]   c_we;
    logic [3:0]   c_waddr;
    logic [63:0]  c_wdata;
    logic         c_rsv_valid;
    logic [3:0]   c_rsv_addr;
    logic [15:0]  c_busy_vec;
    logic         c_wr_conflict;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata), .rsv_valid(a_rsv_valid),
        .rsv_addr(a_rsv_addr), .busy_vec(a_busy_vec), .wr_conflict(a_wr_conflict)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata), .rsv_valid(b_rsv_valid),
        .rsv_addr(b_rsv_addr), .busy_vec(b_busy_vec), .wr_conflict(b_wr_conflict)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .raddr(c_raddr), .rdata(c_rdata), .rbusy(c_rbusy),
        .we(c_we), .waddr(c_waddr), .wdata(c_wdata), .rsv_valid(c_rsv_valid),
        .rsv_addr(c_rsv_addr), .busy_vec(c_busy_vec), .wr_conflict(c_wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic exp_val(input string tag, input logic [63:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h, nothing expected", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
            $display("check %s obs=%h exp=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        a_we        = '0;
        a_rsv_valid = 1'b0;
        b_we        = '0;
        b_rsv_valid = 1'b0;
        c_we        = '0;
        c_rsv_valid = 1'b0;
    endtask

    task automatic a_wr(input int j, input logic [4:0] ad, input logic [31:0] d);
        a_we[j]            = 1'b1;
        a_waddr[j*5 +: 5]  = ad;
        a_wdata[j*32 +: 32] = d;
    endtask

    task automatic a_rsv(input logic [4:0] ad);
        a_rsv_valid = 1'b1;
        a_rsv_addr  = ad;
    endtask

    initial begin
        rst_n   = 1'b0;
        a_raddr = '0; a_waddr = '0; a_wdata = '0; a_rsv_addr = '0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_rsv_addr = '0;
        c_raddr = '0; c_waddr = '0; c_wdata = '0; c_rsv_addr = '0;
        idle();
        #2;

        // Reset state; a write during reset must be neither bypassed nor stored
        a_wr(0, 5'd3, 32'h0000CAFE);
        a_raddr[4:0] = 5'd3;
        exp_val("rst_a_rdata_bypass_gated", 64'd0); #1 chk(a_rdata[31:0]);
        exp_val("rst_a_busy_vec", 64'd0);           chk(a_busy_vec);
        exp_val("rst_a_wr_conflict", 64'd0);        chk(a_wr_conflict);
        exp_val("rst_a_rbusy", 64'd0);              chk(a_rbusy);
        exp_val("rst_b_busy_vec", 64'd0);           chk(b_busy_vec);
        exp_val("rst_b_rbusy", 64'd0);              chk(b_rbusy);
        exp_val("rst_b_wr_conflict", 64'd0);        chk(b_wr_conflict);
        exp_val("rst_c_busy_vec", 64'd0);           chk(c_busy_vec);
        exp_val("rst_c_rbusy", 64'd0);              chk(c_rbusy);
        exp_val("rst_c_wr_conflict", 64'd0);        chk(c_wr_conflict);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        exp_val("rst_write_ignored", 64'd0); #1 chk(a_rdata[31:0]);

        // Basic write then read next cycle
        @(negedge clk);
        a_wr(0, 5'd3, 32'h12345678);
        @(negedge clk);
        idle();
        a_raddr[4:0] = 5'd3;
        exp_val("basic_read_reg3", 64'h12345678); #1 chk(a_rdata[31:0]);

        // Zero register: write and reserve are ignored
        @(negedge clk);
        a_wr(0, 5'd0, 32'hFFFFFFFF);
        a_rsv(5'd0);
        a_raddr[9:5] = 5'd0;
        exp_val("zero_no_bypass", 64'd0); #1 chk(a_rdata[63:32]);
        @(negedge clk);
        idle();
        a_raddr[4:0] = 5'd0;
        exp_val("zero_read", 64'd0);     #1 chk(a_rdata[31:0]);
        exp_val("zero_rsv_busy", 64'd0); chk(a_busy_vec[0]);
        exp_val("zero_rbusy", 64'd0);    chk(a_rbusy[0]);

        // Bypass on (a) versus off (b)
        @(negedge clk);
        a_wr(0, 5'd9, 32'hA5A5A5A5);
        a_raddr[9:5] = 5'd9;
        b_we = 1'b1; b_waddr = 5'd9; b_wdata = 32'hA5A5A5A5;
        b_raddr[9:5] = 5'd9;
        exp_val("bypass_on_same_cycle", 64'hA5A5A5A5); #1 chk(a_rdata[63:32]);
        exp_val("bypass_off_old_value", 64'd0);        chk(b_rdata[63:32]);
        @(negedge clk);
        idle();
        exp_val("bypass_off_next_cycle", 64'hA5A5A5A5); #1 chk(b_rdata[63:32]);
        exp_val("bypass_on_stored", 64'hA5A5A5A5);      chk(a_rdata[63:32]);

        // Scoreboard: reserve, write clears, reserve+write stays busy
        @(negedge clk);
        a_rsv(5'd4);
        a_raddr[4:0] = 5'd4;
        exp_val("rsv_rbusy_before_edge", 64'd0); #1 chk(a_rbusy[0]);
        @(negedge clk);
        idle();
        exp_val("rsv_busy_vec4", 64'd1); #1 chk(a_busy_vec[4]);
        exp_val("rsv_rbusy", 64'd1);     chk(a_rbusy[0]);
        a_wr(0, 5'd4, 32'h1);
        exp_val("wr_no_busy_bypass", 64'd1); #1 chk(a_rbusy[0]);
        exp_val("wr_data_bypass", 64'd1);    chk(a_rdata[31:0]);
        @(negedge clk);
        idle();
        exp_val("wr_clears_busy", 64'd0); #1 chk(a_busy_vec[4]);
        exp_val("reg4_is_1", 64'd1);      chk(a_rdata[31:0]);
        a_rsv(5'd4);
        a_wr(0, 5'd4, 32'h77);
        @(negedge clk);
        idle();
        exp_val("rsv_beats_write", 64'd1); #1 chk(a_busy_vec[4]);
        exp_val("reg4_written", 64'h77);   chk(a_rdata[31:0]);
        a_rsv(5'd4);
        @(negedge clk);
        idle();
        exp_val("rsv_already_busy", 64'd1); #1 chk(a_busy_vec[4]);

        // Multi-write to one address: highest port wins, one-cycle conflict pulse
        a_wr(0, 5'd10, 32'h111);
        a_wr(1, 5'd10, 32'h222);
        a_raddr[4:0] = 5'd10;
        exp_val("mw_same_bypass", 64'h222); #1 chk(a_rdata[31:0]);
        @(negedge clk);
        idle();
        exp_val("mw_conflict_set", 64'd1); #1 chk(a_wr_conflict);
        exp_val("mw_reg10", 64'h222);      chk(a_rdata[31:0]);
        @(negedge clk);
        exp_val("mw_conflict_one_cycle", 64'd0); #1 chk(a_wr_conflict);

        // Different addresses: both stored, no conflict
        a_wr(0, 5'd10, 32'h111);
        a_wr(1, 5'd11, 32'h222);
        a_raddr[9:5] = 5'd11;
        @(negedge clk);
        idle();
        exp_val("mw_diff_conflict", 64'd0); #1 chk(a_wr_conflict);
        exp_val("mw_diff_reg10", 64'h111);  chk(a_rdata[31:0]);
        exp_val("mw_diff_reg11", 64'h222);  chk(a_rdata[63:32]);

        // Both ports to register 0 are not effective, so no conflict
        a_wr(0, 5'd0, 32'h1);
        a_wr(1, 5'd0, 32'h2);
        @(negedge clk);
        idle();
        exp_val("mw_zero_no_conflict", 64'd0); #1 chk(a_wr_conflict);

        // Wide instance: register 0 is ordinary, read on three ports at once
        c_we = 1'b1; c_waddr = 4'd0; c_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        c_rsv_valid = 1'b1; c_rsv_addr = 4'd0;
        @(negedge clk);
        idle();
        c_raddr = '0;
        exp_val("c_port0_reg0", 64'hFFFF_FFFF_FFFF_FFFF); #1 chk(c_rdata[63:0]);
        exp_val("c_port1_reg0", 64'hFFFF_FFFF_FFFF_FFFF); chk(c_rdata[127:64]);
        exp_val("c_port2_reg0", 64'hFFFF_FFFF_FFFF_FFFF); chk(c_rdata[191:128]);
        exp_val("c_busy_reg0", 64'd1);                    chk(c_busy_vec[0]);
        exp_val("c_rbusy_all", 64'd7);                    chk(c_rbusy);
        exp_val("c_no_conflict", 64'd0);                  chk(c_wr_conflict);

        // Reset mid-operation
        a_wr(0, 5'd5, 32'hDEADBEEF);
        a_rsv(5'd7);
        @(negedge clk);
        idle();
        a_wr(0, 5'd12, 32'h1);
        a_wr(1, 5'd12, 32'h2);
        @(negedge clk);
        idle();
        a_raddr[4:0] = 5'd5;
        a_raddr[9:5] = 5'd12;
        exp_val("pre_rst_reg5", 64'hDEADBEEF); #1 chk(a_rdata[31:0]);
        exp_val("pre_rst_busy7", 64'd1);       chk(a_busy_vec[7]);
        exp_val("pre_rst_conflict", 64'd1);    chk(a_wr_conflict);
        #1 rst_n = 1'b0;
        exp_val("mid_rst_rdata0", 64'd0);    #1 chk(a_rdata[31:0]);
        exp_val("mid_rst_rdata1", 64'd0);    chk(a_rdata[63:32]);
        exp_val("mid_rst_busy_vec", 64'd0);  chk(a_busy_vec);
        exp_val("mid_rst_conflict", 64'd0);  chk(a_wr_conflict);
        exp_val("mid_rst_c_rdata", 64'd0);   chk(c_rdata[63:0]);
        exp_val("mid_rst_c_busy", 64'd0);    chk(c_busy_vec);
        @(negedge clk);
        rst_n = 1'b1;
        exp_val("post_rst_reg5", 64'd0);  #1 chk(a_rdata[31:0]);
        exp_val("post_rst_reg12", 64'd0); chk(a_rdata[63:32]);
        exp_val("post_rst_c_reg0", 64'd0); chk(c_rdata[63:0]);

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core; successor to the single-write, two-read register file.
- Configurable width, depth, read-port count and write-port count.
- Adds asynchronous reset clearing, optional write-to-read bypass, a per-register busy scoreboard for in-flight writes, and a registered write-conflict flag.
- Sits between decode (reads, reservations) and writeback (writes) so a multi-issue pipeline can detect RAW hazards.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS).
- NRD, 2, number of read ports (>=1).
- NWR, 1, number of write ports (>=1).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is ordinary.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raddr  input  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  output  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]; combinational.
- rbusy  output  NRD  busy bit of each read address; combinational.
- we  input  NWR  per-port write enable.
- waddr  input  NWR*AW  write addresses.
- wdata  input  NWR*XLEN  write data.
- rsv_valid  input  1  reserve the register at rsv_addr (mark busy).
- rsv_addr  input  AW  register to reserve.
- busy_vec  output  NREGS  full scoreboard, registered.
- wr_conflict  output  1  registered one-cycle pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers clear to 0; busy_vec = 0; wr_conflict = 0.
  - While rst_n is low: rdata = 0, rbusy = 0, and writes and reservations are ignored. Bypass is gated by rst_n.
  - Release is sampled at the first rising clk edge with rst_n high.
- Effective write: write port j is effective iff we[j]=1, and not (ZERO_REG=1 and waddr_j=0).
- Write commit, on the rising clk edge:
  - Every effective port updates reg[waddr_j] with wdata_j.
  - If several effective ports target the same address, the highest-index port wins.
- Read port i (combinational):
  - If ZERO_REG=1 and raddr_i=0: rdata_i = 0.
  - Else if BYPASS=1 and some effective write port targets raddr_i: rdata_i = wdata of the highest-index such port.
  - Else: rdata_i = reg[raddr_i].
  - Read latency is 0 cycles. Write-to-read latency is 0 with BYPASS=1 and 1 cycle with BYPASS=0.
- Scoreboard, per register r at each clock edge, evaluated in priority order:
  - rsv_valid=1 and rsv_addr=r (and not the ZERO_REG address 0): busy[r] <= 1. A reservation wins over a same-cycle write to r, so the new producer stays pending.
  - Else, an effective write to r: busy[r] <= 0.
  - Else: busy[r] holds.
  - Reserving an already-busy register keeps it busy (no counting; single outstanding producer per register).
  - A write to a non-busy register is legal and leaves busy at 0.
- rbusy_i = busy_vec[raddr_i]; always 0 for address 0 when ZERO_REG=1.
  - No bypass on busy: a same-cycle write does not clear rbusy combinationally.
- wr_conflict: registered high for exactly one cycle after any edge where two or more effective write ports share an address; otherwise 0.
- Out-of-range addresses cannot occur (NREGS is a power of two).

Test Plan:
- Reset mid-operation: write reg5=0xDEADBEEF, reserve reg7, then pulse rst_n low between edges -> immediately rdata=0 for all addresses, busy_vec=0, wr_conflict=0; after release, read reg5 -> 0.
- Basic write/read and zero register (ZERO_REG=1): write reg3=0x12345678, next cycle raddr0=3 -> 0x12345678. Write reg0=0xFFFFFFFF, then read reg0 -> 0; rsv_addr=0 -> busy_vec[0]=0.
- Bypass: with BYPASS=1, in the same cycle write reg9=0xA5A5A5A5 and raddr1=9 -> rdata1=0xA5A5A5A5 combinationally. With BYPASS=0 the same stimulus returns the old value 0, and 0xA5A5A5A5 the following cycle.
- Scoreboard: reserve reg4 -> busy_vec[4]=1 next cycle and rbusy=1 for raddr=4. Write reg4=0x1 -> busy clears the following cycle. Reserve and write reg4 in the same cycle -> busy stays 1 and reg4=written value.
- Multi-write (NWR=2): ports 0 and 1 both write reg10 with 0x111 and 0x222 -> reg10=0x222 and wr_conflict=1 for exactly one cycle. Different addresses (reg10=0x111, reg11=0x222) -> both stored, wr_conflict=0.
- Parameter sweep (XLEN=64, NREGS=16, NRD=3, ZERO_REG=0): write reg0=0xFFFF_FFFF_FFFF_FFFF -> read back intact on all three read ports simultaneously.
